// File: rtl/phy_reset_seq_pkg.sv
// phy_reset_seq_pkg: shared eth state encoding and ms-to-cycle conversion
package phy_reset_seq_pkg;
  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } phy_state_t;
  function automatic logic [31:0] ms_to_cyc(input int unsigned clk_fre, input int unsigned ms);
    return 32'(clk_fre * 32'd1000 * ms);
  endfunction
endpackage

// File: rtl/phy_reset_seq_bit_sync.sv
// bit_sync: 2-flop synchronizer with synchronous active-high clear
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/phy_reset_seq.sv
// phy_reset_seq: PHY hardware-reset sequencer with link timeout and bounded retries
module phy_reset_seq
  import phy_reset_seq_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned ASSERT_MS = 10,
  parameter int unsigned SETTLE_MS = 50,
  parameter int unsigned LINK_MS   = 3000,
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       link_up,
  output logic       phy_rst_n,
  output logic       phy_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);
  localparam logic [31:0] A_LAST = ms_to_cyc(CLK_FRE, ASSERT_MS) - 32'd1;
  localparam logic [31:0] S_LAST = ms_to_cyc(CLK_FRE, SETTLE_MS) - 32'd1;
  localparam logic [31:0] L_LAST = ms_to_cyc(CLK_FRE, LINK_MS) - 32'd1;
  localparam logic [1:0]  RMAX   = 2'(RETRY_MAX);
  phy_state_t  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [1:0]  retry_nxt;
  logic        link_s;
  logic        counting;
  bit_sync u_link_sync (
    .clk(clk),
    .rst(rst),
    .d  (link_up),
    .q  (link_s)
  );
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (req && state != ST_ASSERT) begin
      state_nxt = ST_ASSERT;
      retry_nxt = 2'd0;
    end else begin
      case (state)
        ST_ASSERT:    state_nxt = (cnt == A_LAST) ? ST_SETTLE : ST_ASSERT;
        ST_SETTLE:    state_nxt = (cnt == S_LAST) ? ST_WAIT_LINK : ST_SETTLE;
        ST_WAIT_LINK: begin
          if (link_s) begin
            state_nxt = ST_READY;
            retry_nxt = 2'd0;
          end else if (cnt == L_LAST) begin
            state_nxt = (retry_cnt < RMAX) ? ST_ASSERT : ST_FAULT;
            retry_nxt = (retry_cnt < RMAX) ? retry_cnt + 2'd1 : retry_cnt;
          end
        end
        ST_READY:     state_nxt = link_s ? ST_READY : ST_WAIT_LINK;
        ST_FAULT:     state_nxt = ST_FAULT;
        default:      state_nxt = ST_ASSERT;
      endcase
    end
  end
  // every transition restarts the counter; a req ignored in ASSERT keeps it running
  assign counting = (state == ST_ASSERT) || (state == ST_SETTLE) || (state == ST_WAIT_LINK);
  assign cnt_nxt  = (state_nxt != state) ? 32'd0 : counting ? cnt + 32'd1 : 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ASSERT;
      cnt       <= 32'd0;
      retry_cnt <= 2'd0;
      phy_rst_n <= 1'b0;
      phy_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      phy_rst_n <= state_nxt != ST_ASSERT;
      phy_ready <= state_nxt == ST_READY;
      fault     <= state_nxt == ST_FAULT;
    end
  end
  assign state_o = state;
endmodule
